// File: rtl/seq_alu_if.sv
// Request/result handshake bundle for seq_alu.
// The slave modport faces the ALU; the master modport faces the requester/consumer.
interface seq_alu_if #(parameter int WIDTH = 4);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in1;
  logic [WIDTH-1:0]     in2;
  logic [1:0]           opcode;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out;
  logic [WIDTH-1:0]     rem;
  logic                 dz;

  modport slave (
    input  in_valid, in1, in2, opcode, out_ready,
    output in_ready, out_valid, out, rem, dz
  );

  modport master (
    output in_valid, in1, in2, opcode, out_ready,
    input  in_ready, out_valid, out, rem, dz
  );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle add/sub, WIDTH-cycle shift-add multiply and
// restoring divide, with a valid/ready handshake on both request and result.
module seq_alu #(
  parameter int WIDTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  seq_alu_if.slave   bus
);

  localparam int OW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_is_div;
  logic [OW-1:0]   r_acc;
  logic [OW-1:0]   r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_prem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvsr;
  logic [OW-1:0]   r_out;
  logic [WIDTH-1:0] r_rem;
  logic            r_dz;

  logic [OW-1:0]    w_a, w_b;
  logic [OW-1:0]    w_acc_nxt;
  logic [WIDTH:0]   w_shift, w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_prem_nxt, w_quo_nxt;
  logic [OW-1:0]    w_quo_p1;

  assign w_a = {{WIDTH{1'b0}}, bus.in1};
  assign w_b = {{WIDTH{1'b0}}, bus.in2};

  // One multiplier bit per cycle: add the shifted multiplicand when the LSB is set.
  assign w_acc_nxt = r_mplier[0] ? r_acc + r_mcand : r_acc;

  // Restoring step: bring in the next dividend bit, subtract if it fits.
  assign w_shift    = {r_prem, r_quo[WIDTH-1]};
  assign w_ge       = w_shift >= {1'b0, r_dvsr};
  assign w_diff     = w_shift - {1'b0, r_dvsr};
  assign w_prem_nxt = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quo_nxt  = {r_quo[WIDTH-2:0], w_ge};
  assign w_quo_p1   = {{WIDTH{1'b0}}, w_quo_nxt} + OW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prem   <= '0;
      r_quo    <= '0;
      r_dvsr   <= '0;
      r_out    <= '0;
      r_rem    <= '0;
      r_dz     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.in_valid) begin
          r_cnt    <= '0;
          r_is_div <= (bus.opcode == OP_DIV);
          r_acc    <= '0;
          r_mcand  <= w_a;
          r_mplier <= bus.in2;
          r_prem   <= '0;
          r_quo    <= bus.in1;
          r_dvsr   <= bus.in2;
          case (bus.opcode)
            OP_ADD: begin
              r_out <= w_a + w_b; r_rem <= '0; r_dz <= 1'b0; r_state <= DONE;
            end
            OP_SUB: begin
              r_out <= w_a - w_b; r_rem <= '0; r_dz <= 1'b0; r_state <= DONE;
            end
            OP_MUL: r_state <= BUSY;
            default: begin
              if (bus.in2 == '0) begin
                r_out <= '0; r_rem <= '0; r_dz <= 1'b1; r_state <= DONE;
              end else begin
                r_state <= BUSY;
              end
            end
          endcase
        end
        BUSY: begin
          r_cnt    <= r_cnt + CW'(1);
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_prem   <= w_prem_nxt;
          r_quo    <= w_quo_nxt;
          if (r_cnt == LAST) begin
            r_state <= DONE;
            r_dz    <= 1'b0;
            // Divide reports quotient+1 in out and the remainder separately.
            if (r_is_div) begin
              r_out <= w_quo_p1;
              r_rem <= w_prem_nxt;
            end else begin
              r_out <= w_acc_nxt;
              r_rem <= '0;
            end
          end
        end
        DONE: if (bus.out_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.out       = r_out;
  assign bus.rem       = r_rem;
  assign bus.dz        = r_dz;

endmodule

// File: tb/tb_seq_alu.sv
// Randomized and directed bench for seq_alu at WIDTH=4 against an arithmetic
// reference model (results and acceptance-to-valid latency).
module tb_seq_alu;
  localparam int W  = 4;
  localparam int OW = 2 * W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(W)) ifc();
  seq_alu #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [OW-1:0] out;
    logic [W-1:0]  rem;
    logic          dz;
    int            lat;
  } exp_t;

  typedef struct {
    logic [1:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [OW-1:0] o;
    logic [W-1:0]  r;
    logic          dz;
    int            lat;
  } vec_t;

  vec_t vecs[11] = '{
    '{2'd0, 4'hF, 4'hF, 8'h1E, 4'h0, 1'b0, 1},
    '{2'd1, 4'h3, 4'h5, 8'hFE, 4'h0, 1'b0, 1},
    '{2'd2, 4'hF, 4'hF, 8'hE1, 4'h0, 1'b0, 5},
    '{2'd3, 4'hD, 4'h4, 8'h04, 4'h1, 1'b0, 5},
    '{2'd3, 4'h7, 4'h0, 8'h00, 4'h0, 1'b1, 1},
    '{2'd0, 4'h0, 4'h0, 8'h00, 4'h0, 1'b0, 1},
    '{2'd1, 4'h0, 4'hF, 8'hF1, 4'h0, 1'b0, 1},
    '{2'd2, 4'h0, 4'hF, 8'h00, 4'h0, 1'b0, 5},
    '{2'd3, 4'hF, 4'h1, 8'h10, 4'h0, 1'b0, 5},
    '{2'd3, 4'h3, 4'hF, 8'h01, 4'h3, 1'b0, 5},
    '{2'd3, 4'hF, 4'hF, 8'h02, 4'h0, 1'b0, 5}
  };

  function automatic exp_t ref_model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int ia = int'(a);
    int ib = int'(b);
    e.rem = '0; e.dz = 1'b0; e.lat = 1; e.out = '0;
    case (op)
      2'd0: e.out = OW'(ia + ib);
      2'd1: e.out = OW'(ia - ib);
      2'd2: begin e.out = OW'(ia * ib); e.lat = W + 1; end
      default: begin
        if (ib == 0) e.dz = 1'b1;
        else begin
          e.out = OW'(ia / ib + 1);
          e.rem = W'(ia % ib);
          e.lat = W + 1;
        end
      end
    endcase
    return e;
  endfunction

  // Presents one request (DUT assumed idle), then waits for out_valid with
  // junk on the inputs; lat counts edges from the accepting edge inclusive.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat, output bit to);
    ifc.in_valid = 1'b1; ifc.opcode = op; ifc.in1 = a; ifc.in2 = b;
    @(posedge clk); #1;
    lat = 1; to = 1'b0;
    while (!ifc.out_valid) begin
      ifc.in_valid = 1'($urandom_range(0, 1));
      ifc.opcode = 2'($urandom); ifc.in1 = W'($urandom); ifc.in2 = W'($urandom);
      if (lat >= 40) begin to = 1'b1; break; end
      @(posedge clk); #1;
      lat++;
    end
    ifc.in_valid = 1'b0;
  endtask

  task automatic release_out();
    ifc.out_ready = 1'b1;
    @(posedge clk); #1;
    ifc.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (ifc.in_ready !== 1'b1 || ifc.out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1/0", ifc.in_ready, ifc.out_valid);
    end
    total++;
    if (ifc.out !== '0 || ifc.rem !== '0 || ifc.dz !== 1'b0) begin
      bad++; $display("FAIL reset_data: out=%h rem=%h dz=%b want 0", ifc.out, ifc.rem, ifc.dz);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ifc.in_valid = 1'b1; ifc.opcode = 2'd0; ifc.in1 = 4'h1; ifc.in2 = 4'h2;
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    total++;
    if (ifc.out_valid !== 1'b1 || ifc.out !== 8'h03) begin
      bad++; $display("FAIL first_accept: out_valid=%b out=%h want 1/03", ifc.out_valid, ifc.out);
    end
    release_out();
  endtask

  task automatic test_directed();
    int lat; bit to;
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, lat, to);
      total++;
      if (to || lat != vecs[i].lat) begin
        bad++; $display("FAIL dir%0d_lat: got %0d (timeout=%0d) want %0d", i, lat, to, vecs[i].lat);
      end
      total++;
      if (ifc.out !== vecs[i].o || ifc.rem !== vecs[i].r || ifc.dz !== vecs[i].dz) begin
        bad++; $display("FAIL dir%0d_res: got out=%h rem=%h dz=%b want %h/%h/%b",
                        i, ifc.out, ifc.rem, ifc.dz, vecs[i].o, vecs[i].r, vecs[i].dz);
      end
      release_out();
      total++;
      if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1) begin
        bad++; $display("FAIL dir%0d_idle: out_valid=%b in_ready=%b want 0/1", i, ifc.out_valid, ifc.in_ready);
      end
    end
  endtask

  task automatic test_random();
    int lat; bit to; exp_t e;
    logic [1:0] op; logic [W-1:0] a, b;
    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom); a = W'($urandom); b = W'($urandom);
      if ($urandom_range(0, 5) == 0) b = '0;
      e = ref_model(op, a, b);
      issue(op, a, b, lat, to);
      total++;
      if (to || lat != e.lat || ifc.out !== e.out || ifc.rem !== e.rem || ifc.dz !== e.dz) begin
        bad++; $display("FAIL rand%0d op=%0d a=%h b=%h: got out=%h rem=%h dz=%b lat=%0d want %h/%h/%b lat=%0d",
                        i, op, a, b, ifc.out, ifc.rem, ifc.dz, lat, e.out, e.rem, e.dz, e.lat);
      end
      release_out();
    end
  endtask

  task automatic test_hold();
    int lat; bit to;
    issue(2'd2, 4'hF, 4'hF, lat, to);
    total++;
    if (to || lat != 5) begin
      bad++; $display("FAIL hold_lat: got %0d want 5", lat);
    end
    for (int i = 0; i < 10; i++) begin
      ifc.in_valid = 1'($urandom_range(0, 1));
      ifc.opcode = 2'($urandom); ifc.in1 = W'($urandom); ifc.in2 = W'($urandom);
      @(posedge clk); #1;
      total++;
      if (ifc.out_valid !== 1'b1 || ifc.out !== 8'hE1 || ifc.in_ready !== 1'b0) begin
        bad++; $display("FAIL hold%0d: out_valid=%b out=%h in_ready=%b want 1/E1/0",
                        i, ifc.out_valid, ifc.out, ifc.in_ready);
      end
    end
    // Request offered on the draining edge must not be taken.
    ifc.in_valid = 1'b1; ifc.opcode = 2'd0; ifc.in1 = 4'h1; ifc.in2 = 4'h1;
    ifc.out_ready = 1'b1;
    @(posedge clk); #1;
    ifc.in_valid = 1'b0; ifc.out_ready = 1'b0;
    total++;
    if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1) begin
      bad++; $display("FAIL drain: out_valid=%b in_ready=%b want 0/1", ifc.out_valid, ifc.in_ready);
    end
    @(posedge clk); #1;
    total++;
    if (ifc.out_valid !== 1'b0 || ifc.out !== 8'hE1) begin
      bad++; $display("FAIL idle_hold: out_valid=%b out=%h want 0/E1", ifc.out_valid, ifc.out);
    end
  endtask

  task automatic test_reset_busy();
    bit seen = 1'b0;
    ifc.in_valid = 1'b1; ifc.opcode = 2'd3; ifc.in1 = 4'hD; ifc.in2 = 4'h4;
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (ifc.out !== '0 || ifc.rem !== '0 || ifc.dz !== 1'b0 || ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1) begin
      bad++; $display("FAIL rst_busy: out=%h rem=%h dz=%b out_valid=%b in_ready=%b want 0/0/0/0/1",
                      ifc.out, ifc.rem, ifc.dz, ifc.out_valid, ifc.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (ifc.out_valid) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++; $display("FAIL rst_ghost: out_valid seen=%b want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    exp_t q[$];
    exp_t e;
    int acc = 0, pop = 0, cyc = 0;
    while ((acc < 20 || pop < 20) && cyc < 3000) begin
      if (acc < 20) begin
        ifc.in_valid = 1'b1;
        ifc.opcode = 2'($urandom); ifc.in1 = W'($urandom); ifc.in2 = W'($urandom);
        if ($urandom_range(0, 7) == 0) ifc.in2 = '0;
      end else begin
        ifc.in_valid = 1'b0;
      end
      ifc.out_ready = 1'($urandom_range(0, 1));
      if (ifc.in_valid && ifc.in_ready) begin
        q.push_back(ref_model(ifc.opcode, ifc.in1, ifc.in2));
        acc++;
      end
      if (ifc.out_valid && ifc.out_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL b2b_extra: result out=%h with nothing outstanding", ifc.out);
        end else begin
          e = q.pop_front();
          if (ifc.out !== e.out || ifc.rem !== e.rem || ifc.dz !== e.dz) begin
            bad++; $display("FAIL b2b%0d: got out=%h rem=%h dz=%b want %h/%h/%b",
                            pop, ifc.out, ifc.rem, ifc.dz, e.out, e.rem, e.dz);
          end
        end
        pop++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    ifc.in_valid = 1'b0; ifc.out_ready = 1'b0;
    total++;
    if (acc != 20 || pop != 20 || q.size() != 0) begin
      bad++; $display("FAIL b2b_count: accepted=%0d results=%0d pending=%0d want 20/20/0", acc, pop, q.size());
    end
  endtask

  initial begin
    ifc.in_valid = 1'b0; ifc.out_ready = 1'b0;
    ifc.opcode = '0; ifc.in1 = '0; ifc.in2 = '0;
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_reset_busy();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, meaning operand width in bits; legal range 2..16.
REQ-002 SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  request valid.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 in1  input  WIDTH  operand A, unsigned.
REQ-008 in2  input  WIDTH  operand B, unsigned.
REQ-009 opcode  input  2  operation: 00 add, 01 sub, 10 mul, 11 div.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 out  output  2*WIDTH  result.
REQ-013 rem  output  WIDTH  division remainder; 0 for other ops.
REQ-014 dz  output  1  divide-by-zero flag for the current result.

Function
REQ-015 SHALL capture in1, in2 and opcode on a rising clk edge where in_valid && in_ready (acceptance).
REQ-016 SHALL implement FSM states IDLE, BUSY, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-017 IDLE->DONE on acceptance for add, sub, or div with in2==0; IDLE->BUSY on acceptance for mul, or div with in2!=0.
REQ-018 BUSY SHALL last exactly WIDTH cycles, counted by an internal counter cleared on acceptance; ->DONE on the edge ending the WIDTH-th BUSY cycle.
REQ-019 Latency: out_valid SHALL rise 1 cycle after acceptance for add/sub/div-by-zero and WIDTH+1 cycles after acceptance for mul/div.
REQ-020 DONE SHALL hold out, rem, dz stable until out_valid && out_ready, then ->IDLE on that edge; no new request is accepted in that same cycle.
REQ-021 add: out = zero-extended in1 + in2 (no overflow possible in 2*WIDTH bits).
REQ-022 sub: out = (in1 - in2) mod 2^(2*WIDTH), operands zero-extended first (e.g. WIDTH=4, 3-5 = 0xFE).
REQ-023 mul: out = in1*in2 via iterative shift-add, one multiplier bit per BUSY cycle; full 2*WIDTH-bit product.
REQ-024 div, in2!=0: restoring division, one quotient bit per BUSY cycle; out = zero-extended quotient + 1; rem = in1 mod in2; dz=0.
REQ-025 div, in2==0: out=0, rem=0, dz=1; no BUSY cycles.
REQ-026 dz SHALL be 0 for all non-div ops; rem SHALL be 0 for all non-div ops.
REQ-027 Input changes while not in IDLE SHALL have no effect on the in-flight result.
REQ-028 in_valid deasserted in IDLE: remain IDLE, outputs hold previous values but out_valid=0.
REQ-029 out_ready asserted outside DONE SHALL be ignored.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, counter 0, out=0, rem=0, dz=0, out_valid=0, in_ready=1 regardless of clk.
REQ-031 Reset asserted mid-BUSY or mid-DONE SHALL abandon the operation; no out_valid pulse follows reset release.
REQ-032 First acceptance is possible on the first rising edge with rst_n high.

Verification (WIDTH=4)
REQ-033 add 0xF+0xF, out_ready=1 -> out_valid 1 cycle after acceptance, out=0x1E, dz=0, rem=0.
REQ-034 sub 3-5 -> out=0xFE after 1 cycle; mul 0xF*0xF -> out=0xE1 exactly 5 cycles after acceptance.
REQ-035 div 13/4 -> out=0x04 (3+1), rem=1, dz=0 after 5 cycles; div 7/0 -> out=0, rem=0, dz=1 after 1 cycle.
REQ-036 mul result with out_ready=0 for 10 cycles -> out_valid and out stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next edge.
REQ-037 rst_n low during 3rd BUSY cycle of div -> all outputs zero immediately, in_ready=1; no out_valid after release.
REQ-038 Back-to-back: 20 random requests with in_valid held high and random out_ready -> every result matches reference model, in order, none dropped or duplicated.
